// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared constants, op indices and immediate helpers for the decode stage
package id_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int OP_W  = 47;

  // one-hot bit positions of the alu instructions vector
  localparam int OP_LUI    = 0;
  localparam int OP_AUIPC  = 1;
  localparam int OP_JAL    = 2;
  localparam int OP_JALR   = 3;
  localparam int OP_BEQ    = 4;
  localparam int OP_BNE    = 5;
  localparam int OP_BLT    = 6;
  localparam int OP_BGE    = 7;
  localparam int OP_BLTU   = 8;
  localparam int OP_BGEU   = 9;
  localparam int OP_LB     = 10;
  localparam int OP_LH     = 11;
  localparam int OP_LW     = 12;
  localparam int OP_LBU    = 13;
  localparam int OP_LHU    = 14;
  localparam int OP_SB     = 15;
  localparam int OP_SH     = 16;
  localparam int OP_SW     = 17;
  localparam int OP_ADDI   = 18;
  localparam int OP_SLTI   = 19;
  localparam int OP_SLTIU  = 20;
  localparam int OP_XORI   = 21;
  localparam int OP_ORI    = 22;
  localparam int OP_ANDI   = 23;
  localparam int OP_SLLI   = 24;
  localparam int OP_SRLI   = 25;
  localparam int OP_SRAI   = 26;
  localparam int OP_ADD    = 27;
  localparam int OP_SUB    = 28;
  localparam int OP_SLL    = 29;
  localparam int OP_SLT    = 30;
  localparam int OP_SLTU   = 31;
  localparam int OP_XOR    = 32;
  localparam int OP_SRL    = 33;
  localparam int OP_SRA    = 34;
  localparam int OP_OR     = 35;
  localparam int OP_AND    = 36;
  localparam int OP_MUL    = 37;
  localparam int OP_ECALL  = 45;
  localparam int OP_EBREAK = 46;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef enum logic [1:0] {V1_RS1, V1_ZERO, V1_PC} v1_sel_e;

  function automatic logic [OP_W-1:0] onehot(input int idx);
    return {{(OP_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] i, input imm_fmt_e f);
    case (f)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/id_if.sv
// rtl/id_if.sv - fetch/write-back/alu facing signal bundle of the decode stage
interface id_if;
  import id_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] instructions;
  logic [XLEN-1:0] v1;
  logic [XLEN-1:0] v2;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [XLEN-1:0] pc_out;
  logic            illegal;

  modport master (
    output in_valid, instr, pc, flush, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, instructions, v1, v2, store_data, imm, rd, pc_out, illegal
  );

  modport slave (
    input  in_valid, instr, pc, flush, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, instructions, v1, v2, store_data, imm, rd, pc_out, illegal
  );
endinterface

// File: rtl/id_stage_reg_file.sv
// rtl/id_stage_reg_file.sv - architectural register file, two async reads, one sync write
module reg_file
  import id_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];

  // entry 0 is never written, so it reads back as zero forever
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32IM decode stage with bypassed operand read and one output register
module id_stage (
  input logic clk,
  input logic rst_n,
  id_if.slave bus
);
  import id_pkg::*;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_f;

  assign instr  = bus.instr;
  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  logic [OP_W-1:0] op_d;
  imm_fmt_e        fmt;
  v1_sel_e         v1_sel;
  logic            v2_imm;
  logic            has_rd;
  logic            bad;

  always_comb begin
    op_d   = '0;
    fmt    = IMM_NONE;
    v1_sel = V1_RS1;
    v2_imm = 1'b0;
    has_rd = 1'b0;
    bad    = 1'b0;
    case (opcode)
      OPC_LUI:   begin op_d = onehot(OP_LUI);   fmt = IMM_U; v1_sel = V1_ZERO; v2_imm = 1'b1; has_rd = 1'b1; end
      OPC_AUIPC: begin op_d = onehot(OP_AUIPC); fmt = IMM_U; v1_sel = V1_PC;   v2_imm = 1'b1; has_rd = 1'b1; end
      OPC_JAL:   begin op_d = onehot(OP_JAL);   fmt = IMM_J; v1_sel = V1_PC;   v2_imm = 1'b1; has_rd = 1'b1; end
      OPC_JALR: begin
        op_d = onehot(OP_JALR); fmt = IMM_I; v2_imm = 1'b1; has_rd = 1'b1;
        bad  = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt = IMM_B;
        case (f3)
          3'b000:  op_d = onehot(OP_BEQ);
          3'b001:  op_d = onehot(OP_BNE);
          3'b100:  op_d = onehot(OP_BLT);
          3'b101:  op_d = onehot(OP_BGE);
          3'b110:  op_d = onehot(OP_BLTU);
          3'b111:  op_d = onehot(OP_BGEU);
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        fmt = IMM_I; v2_imm = 1'b1; has_rd = 1'b1;
        case (f3)
          3'b000:  op_d = onehot(OP_LB);
          3'b001:  op_d = onehot(OP_LH);
          3'b010:  op_d = onehot(OP_LW);
          3'b100:  op_d = onehot(OP_LBU);
          3'b101:  op_d = onehot(OP_LHU);
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        fmt = IMM_S; v2_imm = 1'b1;
        case (f3)
          3'b000:  op_d = onehot(OP_SB);
          3'b001:  op_d = onehot(OP_SH);
          3'b010:  op_d = onehot(OP_SW);
          default: bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        fmt = IMM_I; v2_imm = 1'b1; has_rd = 1'b1;
        case (f3)
          3'b000: op_d = onehot(OP_ADDI);
          3'b010: op_d = onehot(OP_SLTI);
          3'b011: op_d = onehot(OP_SLTIU);
          3'b100: op_d = onehot(OP_XORI);
          3'b110: op_d = onehot(OP_ORI);
          3'b111: op_d = onehot(OP_ANDI);
          3'b001: if (f7 == 7'b0000000) op_d = onehot(OP_SLLI); else bad = 1'b1;
          default: begin
            if (f7 == 7'b0000000)      op_d = onehot(OP_SRLI);
            else if (f7 == 7'b0100000) op_d = onehot(OP_SRAI);
            else                       bad  = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        has_rd = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  op_d = onehot(OP_ADD);
              3'b001:  op_d = onehot(OP_SLL);
              3'b010:  op_d = onehot(OP_SLT);
              3'b011:  op_d = onehot(OP_SLTU);
              3'b100:  op_d = onehot(OP_XOR);
              3'b101:  op_d = onehot(OP_SRL);
              3'b110:  op_d = onehot(OP_OR);
              default: op_d = onehot(OP_AND);
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000)      op_d = onehot(OP_SUB);
            else if (f3 == 3'b101) op_d = onehot(OP_SRA);
            else                   bad  = 1'b1;
          end
          7'b0000001: op_d = onehot(OP_MUL + int'(f3));
          default:    bad  = 1'b1;
        endcase
      end
      OPC_FENCE: bad = (f3 != 3'b000);
      OPC_SYSTEM: begin
        if (instr == 32'h0000_0073)      op_d = onehot(OP_ECALL);
        else if (instr == 32'h0010_0073) op_d = onehot(OP_EBREAK);
        else                             bad  = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      op_d   = '0;
      fmt    = IMM_NONE;
      has_rd = 1'b0;
    end
  end

  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] rf1;
  logic [XLEN-1:0] rf2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] v1_d;
  logic [XLEN-1:0] v2_d;

  assign imm_d = gen_imm(instr, fmt);

  reg_file u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .rd1   (rf1),
    .ra2   (rs2),
    .rd2   (rf2),
    .we    (bus.wb_en),
    .wa    (bus.wb_rd),
    .wd    (bus.wb_data)
  );

  // same-cycle write-back wins over the stale register-file contents
  assign rs1_val = (rs1 == 5'd0) ? '0 : (bus.wb_en && bus.wb_rd == rs1) ? bus.wb_data : rf1;
  assign rs2_val = (rs2 == 5'd0) ? '0 : (bus.wb_en && bus.wb_rd == rs2) ? bus.wb_data : rf2;

  always_comb begin
    case (v1_sel)
      V1_ZERO: v1_d = '0;
      V1_PC:   v1_d = bus.pc;
      default: v1_d = rs1_val;
    endcase
    v2_d = v2_imm ? imm_d : rs2_val;
  end

  logic            out_valid_q;
  logic [OP_W-1:0] ops_q;
  logic [XLEN-1:0] v1_q;
  logic [XLEN-1:0] v2_q;
  logic [XLEN-1:0] sd_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc_q;
  logic            ill_q;
  logic [4:0]      held_rs1;
  logic [4:0]      held_rs2;
  logic            v1_from_rs;
  logic            v2_from_rs;

  logic in_ready;
  logic load;
  logic hold;
  logic wb_live;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign load     = bus.in_valid && in_ready;
  assign hold     = out_valid_q && !bus.out_ready;
  assign wb_live  = bus.wb_en && bus.wb_rd != 5'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ops_q       <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      sd_q        <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      ill_q       <= 1'b0;
      held_rs1    <= '0;
      held_rs2    <= '0;
      v1_from_rs  <= 1'b0;
      v2_from_rs  <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      ops_q       <= '0;
      ill_q       <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      ops_q       <= op_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      sd_q        <= rs2_val;
      imm_q       <= imm_d;
      rd_q        <= has_rd ? rd_f : 5'd0;
      pc_q        <= bus.pc;
      ill_q       <= bad;
      held_rs1    <= rs1;
      held_rs2    <= rs2;
      v1_from_rs  <= (v1_sel == V1_RS1);
      v2_from_rs  <= !v2_imm;
    end else if (hold) begin
      // a stalled bundle must not carry an operand older than the register file
      if (wb_live && v1_from_rs && bus.wb_rd == held_rs1) v1_q <= bus.wb_data;
      if (wb_live && v2_from_rs && bus.wb_rd == held_rs2) v2_q <= bus.wb_data;
      if (wb_live && bus.wb_rd == held_rs2)               sd_q <= bus.wb_data;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.instructions = ops_q;
  assign bus.v1           = v1_q;
  assign bus.v2           = v2_q;
  assign bus.store_data   = sd_q;
  assign bus.imm          = imm_q;
  assign bus.rd           = rd_q;
  assign bus.pc_out       = pc_q;
  assign bus.illegal      = ill_q && out_valid_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for the decode stage
module tb_id_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  id_if bus ();

  id_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          full;
    logic [46:0] ops;
    logic        ill;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] sd;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [46:0] bit_of(input int idx);
    logic [46:0] one;
    one = 47'd1;
    return (idx < 0) ? 47'd0 : (one << idx);
  endfunction

  task automatic exp_full(input string tag, input int idx, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] sd, input logic [31:0] imm, input logic [4:0] rd,
                          input logic [31:0] pc);
    exp_t e;
    e.tag = tag; e.full = 1'b1; e.ops = bit_of(idx); e.ill = 1'b0;
    e.v1 = v1; e.v2 = v2; e.sd = sd; e.imm = imm; e.rd = rd; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic exp_part(input string tag, input int idx, input logic ill, input logic [31:0] pc);
    exp_t e;
    e.tag = tag; e.full = 1'b0; e.ops = bit_of(idx); e.ill = ill;
    e.v1 = '0; e.v2 = '0; e.sd = '0; e.imm = '0; e.rd = 5'd0; e.pc = pc;
    sb.push_back(e);
  endtask

  // monitor: every accepted bundle is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_bundle", {17'd0, bus.instructions}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".instructions"}, {17'd0, bus.instructions}, {17'd0, e.ops});
        chk({e.tag, ".illegal"}, {63'd0, bus.illegal}, {63'd0, e.ill});
        chk({e.tag, ".rd"}, {59'd0, bus.rd}, {59'd0, e.rd});
        chk({e.tag, ".pc_out"}, {32'd0, bus.pc_out}, {32'd0, e.pc});
        if (e.full) begin
          chk({e.tag, ".v1"}, {32'd0, bus.v1}, {32'd0, e.v1});
          chk({e.tag, ".v2"}, {32'd0, bus.v2}, {32'd0, e.v2});
          chk({e.tag, ".store_data"}, {32'd0, bus.store_data}, {32'd0, e.sd});
          chk({e.tag, ".imm"}, {32'd0, bus.imm}, {32'd0, e.imm});
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] p);
    int n;
    bus.instr    = ins;
    bus.pc       = p;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = r;
    bus.wb_data = d;
    @(posedge clk);
    #1;
    bus.wb_en   = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain", {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset.out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset.in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("reset.instructions", {17'd0, bus.instructions}, 64'd0);
    chk("reset.v1", {32'd0, bus.v1}, 64'd0);

    // ADDI x1,x0,5
    exp_full("addi", 18, 32'h0, 32'h5, 32'h0, 32'h5, 5'd1, 32'h0);
    send(32'h0050_0093, 32'h0);
    chk("addi.latency", {63'd0, bus.out_valid}, 64'd1);

    // hold with refresh: x2=7, ADD x3,x1,x2 stalled, then x2=9
    drain();
    wb(5'd2, 32'd7);
    bus.out_ready = 1'b0;
    exp_full("add_hold", 27, 32'h0, 32'd9, 32'd9, 32'h0, 5'd3, 32'h4);
    send(32'h0020_81B3, 32'h4);
    chk("hold.out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("hold.in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("hold.v2_before", {32'd0, bus.v2}, 64'd7);
    wb(5'd2, 32'd9);
    chk("hold.v2_after", {32'd0, bus.v2}, 64'd9);
    chk("hold.store_data", {32'd0, bus.store_data}, 64'd9);
    chk("hold.instructions", {17'd0, bus.instructions}, {17'd0, bit_of(27)});
    chk("hold.rd", {59'd0, bus.rd}, 64'd3);
    chk("hold.in_ready2", {63'd0, bus.in_ready}, 64'd0);
    bus.out_ready = 1'b1;

    // same-cycle bypass: SUB x5,x4,x0 with wb x4
    bus.wb_en = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'hDEAD_BEEF;
    exp_full("sub_bypass", 28, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 5'd5, 32'h8);
    send(32'h4002_02B3, 32'h8);
    bus.wb_en = 1'b0;

    // x0 writes are ignored, both earlier and same-cycle
    wb(5'd0, 32'hFFFF_FFFF);
    exp_full("add_x0", 27, 32'h0, 32'h0, 32'h0, 32'h0, 5'd6, 32'hC);
    send(32'h0000_0333, 32'hC);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    exp_full("add_x0_byp", 27, 32'h0, 32'h0, 32'h0, 32'h0, 5'd6, 32'h10);
    send(32'h0000_0333, 32'h10);
    bus.wb_en = 1'b0;

    // flush kills held ADDI x8 and incoming ADDI x9
    drain();
    bus.out_ready = 1'b0;
    send(32'h0010_0413, 32'h14);
    chk("flush.pre_valid", {63'd0, bus.out_valid}, 64'd1);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.instr = 32'h0020_0493; bus.pc = 32'h18;
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush.out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush.instructions", {17'd0, bus.instructions}, 64'd0);
    bus.out_ready = 1'b1;
    exp_full("lui", 0, 32'h0, 32'h1234_5000, 32'h0, 32'h1234_5000, 5'd10, 32'h1C);
    send(32'h1234_5537, 32'h1C);

    // illegal encodings and immediate formats
    exp_part("all_ones", -1, 1'b1, 32'h20);
    send(32'hFFFF_FFFF, 32'h20);
    exp_full("beq_m4", 4, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd0, 32'h24);
    send(32'hFE00_0EE3, 32'h24);
    exp_full("auipc", 1, 32'h100, 32'h1000, 32'h0, 32'h1000, 5'd11, 32'h100);
    send(32'h0000_1597, 32'h100);
    exp_full("sw", 17, 32'hDEAD_BEEF, 32'h8, 32'd9, 32'h8, 5'd0, 32'h104);
    send(32'h0022_2423, 32'h104);
    exp_full("mul", 37, 32'd9, 32'd9, 32'd9, 32'h0, 5'd12, 32'h108);
    send(32'h0221_0633, 32'h108);
    exp_full("jal", 2, 32'h10C, 32'h10, 32'h0, 32'h10, 5'd1, 32'h10C);
    send(32'h0100_00EF, 32'h10C);
    exp_full("srai", 26, 32'hDEAD_BEEF, 32'h404, 32'hDEAD_BEEF, 32'h404, 5'd13, 32'h110);
    send(32'h4042_5693, 32'h110);
    exp_part("ecall", 45, 1'b0, 32'h114);
    send(32'h0000_0073, 32'h114);
    exp_part("fence", -1, 1'b0, 32'h118);
    send(32'h0000_000F, 32'h118);
    exp_part("bad_f7", -1, 1'b1, 32'h11C);
    send(32'h8000_03B3, 32'h11C);
    exp_part("bad_br", -1, 1'b1, 32'h120);
    send(32'h0000_2063, 32'h120);

    drain();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
